// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared arbiter state encoding and timeout length
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, DATA, FETCH} state_t;
  localparam int TIMEOUT_CYCLES = 15;
endpackage

// File: rtl/mem_arb_wdog.sv
// mem_arb_wdog: counts mem_en cycles and flags a stalled access (used only under MEM_ARB_TIMEOUT_EN)
module mem_arb_wdog
  import mem_arb_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic ready,
  output logic timeout
);
  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= en ? cnt + 1'b1 : '0;
  assign timeout = en && !ready && cnt == W'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: data-first fetch/data arbiter onto one memory port; MEM_ARB_TIMEOUT_EN adds a stall watchdog
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              dm_rd,
  input  logic              dm_wr,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_done,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              err
);
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              wr_q, dm_req, if_pend, grant, fin, timeout, err_bad;
  assign dm_req  = (dm_rd || dm_wr) && !dm_done;
  assign if_pend = if_req && !if_done;
`ifdef MEM_ARB_TIMEOUT_EN
  logic err_to_q;
  mem_arb_wdog u_wdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (mem_en),
    .ready  (mem_ready),
    .timeout(timeout)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) err_to_q <= 1'b0;
    else err_to_q <= timeout;
  assign err = err_bad || err_to_q;
`else
  assign timeout = 1'b0;
  assign err     = err_bad;
`endif
  assign fin = state_q != IDLE && (mem_ready || timeout);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  always_comb
    state_d = state_q == IDLE ? (dm_req ? DATA : if_pend ? FETCH : IDLE)
            : fin ? IDLE : state_q;
  always_comb begin
    busy      = state_q != IDLE;
    mem_en    = busy;
    mem_wr    = busy && wr_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    grant     = state_q == IDLE && state_d != IDLE;
    err_bad   = rst_n && state_q == IDLE && dm_req && dm_rd && dm_wr;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
    end else if (grant) begin
      addr_q  <= dm_req ? dm_addr : if_addr;
      wdata_q <= dm_req ? dm_wdata : '0;
      wr_q    <= dm_req && dm_wr;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      if_done  <= 1'b0;
      dm_done  <= 1'b0;
      if_rdata <= '0;
      dm_rdata <= '0;
    end else begin
      if_done <= fin && state_q == FETCH;
      dm_done <= fin && state_q == DATA;
      if (fin && !wr_q && state_q == FETCH) if_rdata <= timeout ? '0 : mem_rdata;
      if (fin && !wr_q && state_q == DATA) dm_rdata <= timeout ? '0 : mem_rdata;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        if_req = 1'b0, if_done, dm_rd = 1'b0, dm_wr = 1'b0, dm_done;
  logic [15:0] if_addr = '0, if_rdata, dm_addr = '0, dm_wdata = '0, dm_rdata;
  logic        mem_en, mem_wr, mem_ready = 1'b0, busy, err;
  logic [15:0] mem_addr, mem_wdata, mem_rdata = '0;
  int          n_tests = 0, n_fail = 0;
  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_done(dm_done),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy), .err(err)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(negedge clk);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    step; step;
    check("rst_busy", busy, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_wr", mem_wr, 0);
    check("rst_done", {if_done, dm_done}, 0);
    check("rst_err", err, 0);
    check("rst_data", {if_rdata, dm_rdata, mem_addr, mem_wdata}, 0);
    rst_n = 1'b1;
    step;
    if_req = 1; if_addr = 16'h0010; #1;
    check("f_idle_en", mem_en, 0);
    step;
    check("f_en", mem_en, 1);
    check("f_addr", mem_addr, 16'h0010);
    check("f_wr", mem_wr, 0);
    check("f_busy", busy, 1);
    mem_ready = 1; mem_rdata = 16'hA5C3;
    step;
    mem_ready = 0;
    check("f_done", if_done, 1);
    check("f_rdata", if_rdata, 16'hA5C3);
    check("f_busy_idle", busy, 0);
    if_req = 0;
    step;
    check("f_done_once", if_done, 0);
    check("f_rdata_hold", if_rdata, 16'hA5C3);
    step;
    if_req = 1; if_addr = 16'h0020; dm_rd = 1; dm_addr = 16'h0200; #1;
    step;
    check("p_data_first", mem_addr, 16'h0200);
    check("p_data_rd", mem_wr, 0);
    mem_ready = 1; mem_rdata = 16'h5555;
    step;
    mem_ready = 0;
    check("p_dm_done", dm_done, 1);
    check("p_if_not_done", if_done, 0);
    check("p_dm_rdata", dm_rdata, 16'h5555);
    check("p_idle_gap", busy, 0);
    dm_rd = 0;
    step;
    check("p_fetch_en", mem_en, 1);
    check("p_fetch_addr", mem_addr, 16'h0020);
    check("p_dm_done_once", dm_done, 0);
    mem_ready = 1; mem_rdata = 16'h7777;
    step;
    mem_ready = 0;
    check("p_if_done", if_done, 1);
    check("p_if_rdata", if_rdata, 16'h7777);
    check("p_dm_hold", dm_rdata, 16'h5555);
    if_req = 0;
    step;
    check("p_idle", busy, 0);
    dm_wr = 1; dm_addr = 16'h0100; dm_wdata = 16'h1234; #1;
    check("w_no_err", err, 0);
    for (int i = 1; i <= 4; i++) begin
      step;
      if (i == 1) begin dm_addr = 16'hFFFF; dm_wdata = 16'hFFFF; end
      if (i == 4) mem_ready = 1;
      #1;
      check($sformatf("w_en%0d", i), mem_en, 1);
      check($sformatf("w_wr%0d", i), mem_wr, 1);
      check($sformatf("w_addr%0d", i), mem_addr, 16'h0100);
      check($sformatf("w_wdata%0d", i), mem_wdata, 16'h1234);
      check($sformatf("w_nodone%0d", i), dm_done, 0);
    end
    step;
    mem_ready = 0;
    check("w_done", dm_done, 1);
    check("w_en_off", mem_en, 0);
    check("w_rdata_hold", dm_rdata, 16'h5555);
    dm_wr = 0;
    step;
    dm_rd = 1; dm_wr = 1; dm_addr = 16'h0300; dm_wdata = 16'hBEEF; #1;
    check("e_err", err, 1);
    step;
    check("e_err_pulse", err, 0);
    check("e_wr", mem_wr, 1);
    check("e_addr", mem_addr, 16'h0300);
    check("e_wdata", mem_wdata, 16'hBEEF);
    mem_ready = 1;
    step;
    mem_ready = 0;
    check("e_done", dm_done, 1);
    check("e_err_clear", err, 0);
    dm_rd = 0; dm_wr = 0;
    step;
    if_req = 1; if_addr = 16'h0040; #1;
    step;
    check("r_en", mem_en, 1);
    rst_n = 0; #1;
    check("r_en_drop", mem_en, 0);
    check("r_busy_drop", busy, 0);
    step;
    check("r_no_done", if_done, 0);
    check("r_rdata_clr", if_rdata, 0);
    check("r_err", err, 0);
    rst_n = 1;
    step;
    check("r_retry_en", mem_en, 1);
    check("r_retry_addr", mem_addr, 16'h0040);
    mem_ready = 1; mem_rdata = 16'h0BAD;
    step;
    mem_ready = 0;
    check("r_retry_done", if_done, 1);
    check("r_retry_rdata", if_rdata, 16'h0BAD);
    if_req = 0;
    step;
    dm_rd = 1; dm_addr = 16'h0500; #1;
    step;
    mem_ready = 1; mem_rdata = 16'h1111;
    step;
    mem_ready = 0;
    check("t_pre_rdata", dm_rdata, 16'h1111);
    dm_rd = 0;
    step;
    dm_rd = 1; dm_addr = 16'h0600; #1;
`ifdef MEM_ARB_TIMEOUT_EN
    for (int i = 1; i <= 15; i++) begin
      step;
      check($sformatf("t_en%0d", i), mem_en, 1);
      check($sformatf("t_nodone%0d", i), dm_done, 0);
    end
    step;
    check("t_done", dm_done, 1);
    check("t_err", err, 1);
    check("t_rdata", dm_rdata, 16'h0000);
    check("t_en_off", mem_en, 0);
    dm_rd = 0;
    step;
    check("t_err_pulse", err, 0);
`else
    for (int i = 1; i <= 20; i++) step;
    check("n_still_busy", busy, 1);
    check("n_no_done", dm_done, 0);
    check("n_no_err", err, 0);
    mem_ready = 1; mem_rdata = 16'h2222;
    step;
    mem_ready = 0;
    check("n_done", dm_done, 1);
    check("n_rdata", dm_rdata, 16'h2222);
    dm_rd = 0;
    step;
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
